ram_responder: RTL
==================

Name: ram_responder

Overview:
- Data-memory responder on the CPU RAM port. It services the CPU's ram_write / ram_read strobes with their 6-bit write and read addresses.
- Storage: a DEPTH x DATA_W synchronous RAM, cleared by a post-reset init sequence.
- Read data returns one cycle after the strobe, qualified by ram_read_valid.
- Sits beside CPU at the top level, driven directly by CPU's RAM outputs.

Parameters:
- ADDR_W, 6, address width; matches ram_write_addr / ram_read_addr.
- DATA_W, 16, word width; matches ram_data_out / ram_data_in.
- DEPTH, 64, number of words; must equal 2**ADDR_W.
- INIT_VALUE, 16'h0000, value written to every word during init.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- ram_write  input  1  write strobe from CPU, one word per cycle asserted
- ram_read  input  1  read strobe from CPU, one word per cycle asserted
- ram_write_addr  input  ADDR_W  write address
- ram_read_addr  input  ADDR_W  read address
- ram_data_out  input  DATA_W  write data (CPU-side name kept)
- ram_data_in  output  DATA_W  read data to CPU (CPU-side name kept)
- ram_read_valid  output  1  one-cycle pulse, ram_data_in valid
- ram_busy  output  1  high while init clear runs; requests not accepted
- ram_drop_err  output  1  sticky; set when a strobe arrives while ram_busy

Behaviour:
- Reset (synchronous, active-high, sampled on rising clk):
  - state <= INIT; init_ptr <= 0.
  - ram_data_in <= 0, ram_read_valid <= 0, ram_busy <= 1, ram_drop_err <= 0.
  - Reset overrides every other input in the same cycle.
- State INIT:
  - Each cycle writes INIT_VALUE to mem[init_ptr], then init_ptr <= init_ptr + 1.
  - When init_ptr == DEPTH-1 is written: state <= READY, ram_busy <= 0 on that edge. Init takes exactly DEPTH cycles after reset deasserts.
  - ram_write / ram_read during INIT are ignored: no memory change and no ram_read_valid. Each such cycle sets ram_drop_err.
- State READY, write:
  - When ram_write is high, mem[ram_write_addr] <= ram_data_out at the edge.
- State READY, read:
  - When ram_read is high, ram_data_in <= mem[ram_read_addr] and ram_read_valid <= 1 at the edge. Latency is 1 cycle.
  - When ram_read is low, ram_read_valid <= 0 and ram_data_in holds its last value.
- Simultaneous read and write:
  - Same address: write-first. ram_data_in returns ram_data_out (the new data), and memory is updated.
  - Different addresses: both are serviced in the same cycle.
- Back-to-back reads: one result per cycle; ram_read_valid stays high continuously.
- Addresses are exactly ADDR_W bits, so there is no out-of-range case. init_ptr wraps to 0 only via reset.
- Reset during READY or mid-init: contents are re-cleared from address 0. Any pending ram_read_valid is cancelled at that edge.
- ram_drop_err:
  - Cleared only by reset.
  - Set in the same cycle as the offending strobe; visible after that edge.
- Transitions: INIT -> READY on the last init write. READY -> READY otherwise. Any state -> INIT on reset.

Optional Feature:
- Macro: RAM_ACCESS_CNT_EN.
- When defined, two extra outputs are added:
  - wr_count (16 bits): counts accepted writes in READY.
  - rd_count (16 bits): counts accepted reads in READY.
- Counter rules:
  - Both reset to 0.
  - Each saturates at 16'hFFFF and does not wrap.
  - Dropped requests during INIT are not counted.
  - A simultaneous read and write increments both.
- When not defined: the ports and counters are absent, and behaviour is otherwise identical.

Test Plan:
- Reset 2 cycles, release; read addresses 0..63 after ram_busy falls -> ram_busy high exactly 64 cycles, every read returns 16'h0000 with ram_read_valid one cycle after each strobe.
- Write 16'hA5A5 to addr 6'd10, next cycle read addr 10 -> ram_data_in = 16'hA5A5 with ram_read_valid pulse one cycle after the read strobe.
- Same cycle: ram_write addr 12 with 16'h1234, ram_read addr 12 -> next cycle ram_data_in = 16'h1234 (write-first); a later read of addr 12 also gives 16'h1234.
- Pulse ram_read at cycle 5 after reset (during INIT) -> no ram_read_valid, ram_drop_err = 1 and stays 1 until the next reset, memory stays all zero.
- Write 16'hBEEF to addr 63, assert reset for 1 cycle, wait for init to finish, read addr 63 -> 16'h0000; also assert reset mid-init at init_ptr = 30 -> ram_busy stays high for a full 64 cycles after the release.
- With RAM_ACCESS_CNT_EN: 3 writes, 2 reads, 1 simultaneous read+write -> wr_count = 4, rd_count = 3; force wr_count to 16'hFFFE, then 3 writes -> 16'hFFFF.

Source files
------------

// File: rtl/ram_responder.sv
// Data-memory responder for the CPU RAM port: synchronous RAM cleared by a post-reset init sweep.
// Define RAM_ACCESS_CNT_EN to add saturating wr_count / rd_count access counters.
module ram_responder #(
  parameter int                ADDR_W     = 6,
  parameter int                DATA_W     = 16,
  parameter int                DEPTH      = 64,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ram_write,
  input  logic              ram_read,
  input  logic [ADDR_W-1:0] ram_write_addr,
  input  logic [ADDR_W-1:0] ram_read_addr,
  input  logic [DATA_W-1:0] ram_data_out,
  output logic [DATA_W-1:0] ram_data_in,
  output logic              ram_read_valid,
  output logic              ram_busy,
`ifdef RAM_ACCESS_CNT_EN
  output logic              ram_drop_err,
  output logic [15:0]       wr_count,
  output logic [15:0]       rd_count
`else
  output logic              ram_drop_err
`endif
);

  typedef enum logic {INIT, READY} state_t;

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] init_ptr;
  logic [DATA_W-1:0] mem [0:DEPTH-1];
  logic              wr_accept;
  logic              rd_accept;

  assign wr_accept = (state_q == READY) && ram_write;
  assign rd_accept = (state_q == READY) && ram_read;
  assign ram_busy  = (state_q == INIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= INIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if ((state_q == INIT) && (init_ptr == LAST_PTR)) begin
      state_d = READY;
    end
  end

  // init_ptr parks on the last address once the sweep completes; only reset rewinds it
  always_ff @(posedge clk) begin
    if (reset) begin
      init_ptr <= '0;
    end else if ((state_q == INIT) && (init_ptr != LAST_PTR)) begin
      init_ptr <= init_ptr + 1'b1;
    end
  end

  // No reset on the array so it maps onto block RAM; the init sweep does the clearing
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == INIT) begin
        mem[init_ptr] <= INIT_VALUE;
      end else if (ram_write) begin
        mem[ram_write_addr] <= ram_data_out;
      end
    end
  end

  // Write-first: a same-address write in the read cycle bypasses the array
  always_ff @(posedge clk) begin
    if (reset) begin
      ram_data_in    <= '0;
      ram_read_valid <= 1'b0;
    end else if (rd_accept) begin
      ram_read_valid <= 1'b1;
      if (ram_write && (ram_write_addr == ram_read_addr)) begin
        ram_data_in <= ram_data_out;
      end else begin
        ram_data_in <= mem[ram_read_addr];
      end
    end else begin
      ram_read_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ram_drop_err <= 1'b0;
    end else if ((state_q == INIT) && (ram_write || ram_read)) begin
      ram_drop_err <= 1'b1;
    end
  end

`ifdef RAM_ACCESS_CNT_EN
  // Counters saturate rather than wrap so a long run never reports a small count
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_count <= '0;
      rd_count <= '0;
    end else begin
      if (wr_accept && (wr_count != 16'hFFFF)) begin
        wr_count <= wr_count + 16'd1;
      end
      if (rd_accept && (rd_count != 16'hFFFF)) begin
        rd_count <= rd_count + 16'd1;
      end
    end
  end
`else
  logic unused_accept;
  assign unused_accept = wr_accept;
`endif

endmodule
